// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle W-bit adder (W = 4*NIBBLES) that processes
// one nibble per clock through a single 4-bit ripple adder, carrying between
// passes in a register. Valid/ready handshake on both sides.
// Optional feature macro: SUB_EN adds the in_sub port (A - B via ~B + 1).

// 4-bit ripple-carry full-adder chain, one full adder per bit.
module nibble_fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
`ifdef SUB_EN
  input  logic                 in_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES:0]   out_sum
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r, acc, acc_nxt;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [3:0]      nib_s;
  logic            nib_co;
  logic [W-1:0]    b_init;
  logic            c_init;

  // Operand B and initial carry as captured on acceptance; subtract is
  // A + ~B + 1, so the inversion happens once here rather than every pass.
`ifdef SUB_EN
  assign b_init = in_sub ? ~in_b : in_b;
  assign c_init = in_sub;
`else
  assign b_init = in_b;
  assign c_init = 1'b0;
`endif

  nibble_fa4 u_fa (
    .a  (a_r[3:0]),
    .b  (b_r[3:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  // New nibble enters at the MSB side; after NIBBLES passes the first
  // (least significant) nibble has reached bit 0. Written as a shift of the
  // concatenation so NIBBLES=1 needs no special slice.
  assign acc_nxt = W'({nib_s, acc} >> 4);

  // Handshake FSM with registered outputs; out_sum only loads on the final pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= b_init;
            carry    <= c_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          acc   <= acc_nxt;
          carry <= nib_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIBBLES - 1)) begin
            out_sum   <= {nib_co, acc_nxt};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a NIBBLES=4 instance for the main
// scenarios and a NIBBLES=1 instance for the single-pass corner.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  // NIBBLES=4 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [16:0] out_sum;
  // NIBBLES=1 instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  in_a1, in_b1;
  logic [4:0]  out_sum1;
`ifdef SUB_EN
  logic        in_sub, in_sub1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
`ifdef SUB_EN
    .in_sub(in_sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1)
  );

  // Present a pair on the 4-nibble DUT, then count edges until out_valid.
  task automatic send(input logic [15:0] a, input logic [15:0] b, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 17'h0) begin
      errors++;
      $display("FAIL reset4: in_ready=%b out_valid=%b out_sum=%h, want 1 0 00000", in_ready, out_valid, out_sum);
    end
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_sum1 !== 5'h0) begin
      errors++;
      $display("FAIL reset1: in_ready=%b out_valid=%b out_sum=%h, want 1 0 00", in_ready1, out_valid1, out_sum1);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nibbles1();
    int lat = 0;
    in_a1 = 4'b0110; in_b1 = 4'b1110; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL nib1_latency: got %0d edges, want 1", lat);
    end
    checks++;
    if (out_sum1 !== 5'b10100) begin
      errors++;
      $display("FAIL nib1_sum: got %b, want 10100", out_sum1);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL nib1_idle: in_ready=%b out_valid=%b, want 1 0", in_ready1, out_valid1);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ripple_latency: got %0d edges, want 4", lat);
    end
    checks++;
    if (out_sum !== 17'h10000) begin
      errors++;
      $display("FAIL ripple_sum: got %h, want 10000", out_sum);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 17'h10000) begin
      errors++;
      $display("FAIL ripple_idle: in_ready=%b out_valid=%b out_sum=%h, want 1 0 10000", in_ready, out_valid, out_sum);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, lat);
    // Offer a different pair while busy; it must be ignored.
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 17'h05555 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b out_sum=%h in_ready=%b, want 1 05555 0", i, out_valid, out_sum, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 17'h05555) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b out_sum=%h, want 1 0 05555", in_ready, out_valid, out_sum);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    out_ready = 1'b1;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;            // accepted
    in_valid = 1'b0;
    @(posedge clk); #1;            // first RUN pass done, now in 2nd RUN cycle
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 17'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop: out_valid=%b out_sum=%h in_ready=%b, want 0 00000 1", out_valid, out_sum, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_noresult: out_valid=%b, want 0", out_valid);
    end
    send(16'h1234, 16'h1111, lat);
    checks++;
    if (lat !== 4 || out_sum !== 17'h02345) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d sum=%h, want 4 02345", lat, out_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    out_ready = 1'b1;
    in_a = 16'h00FF; in_b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;            // first pair accepted
    in_a = 16'h8000; in_b = 16'h8000;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4 || out_sum !== 17'h00100) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d sum=%h, want 4 00100", lat, out_sum);
    end
    @(posedge clk); #1;            // DONE -> IDLE bubble
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;            // second pair accepted here
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4 || out_sum !== 17'h10000) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d sum=%h, want 4 10000", lat, out_sum);
    end
    @(posedge clk); #1;
  endtask

`ifdef SUB_EN
  task automatic test_sub();
    int lat;
    out_ready = 1'b1;
    in_sub = 1'b1;
    send(16'h0005, 16'h0007, lat);
    checks++;
    if (out_sum !== 17'h0FFFE) begin
      errors++;
      $display("FAIL sub_borrow: got %h, want 0FFFE", out_sum);
    end
    @(posedge clk); #1;
    send(16'h0007, 16'h0005, lat);
    checks++;
    if (out_sum !== 17'h10002) begin
      errors++;
      $display("FAIL sub_noborrow: got %h, want 10002", out_sum);
    end
    @(posedge clk); #1;
    in_sub = 1'b0;
    send(16'h0007, 16'h0005, lat);
    checks++;
    if (out_sum !== 17'h0000C) begin
      errors++;
      $display("FAIL sub_addmode: got %h, want 0000C", out_sum);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_a1 = '0; in_b1 = '0;
`ifdef SUB_EN
    in_sub = 1'b0; in_sub1 = 1'b0;
`endif
    test_reset();
    test_nibbles1();
    test_carry_ripple();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
